rsa_two_inv_power_mod: RTL



---
 rtl/rsa_two_inv_power_mod_pkg.sv | 29 ++
 rtl/rsa_mod_half.sv | 25 ++
 rtl/rsa_two_inv_power_mod.sv | 100 ++++++++++
 3 files changed

// File: rtl/rsa_two_inv_power_mod_pkg.sv
// Shared types for the RSA precompute path: key/power widths, job structs and the
// inverse-power FSM encoding.
`default_nettype none

package rsa_two_inv_power_mod_pkg;

   localparam int MOD_WIDTH = 256;
   localparam int INT_WIDTH = MOD_WIDTH;

   typedef logic [MOD_WIDTH-1:0] KeyType;
   typedef logic [MOD_WIDTH:0]   KeyExtType;
   typedef logic [INT_WIDTH-1:0] IntType;

   typedef struct packed {
      IntType power;
      KeyType modulus;
   } RSATwoInvPowerModIn;

   typedef KeyType RSATwoInvPowerModOut;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } inv_state_e;

endpackage

`default_nettype wire

// File: rtl/rsa_mod_half.sv
// Modular halving: (r odd ? r+N : r) >> 1, evaluated one bit wider than the key so
// the carry out of r+N survives the shift.
`default_nettype none

module rsa_mod_half
   import rsa_two_inv_power_mod_pkg::*;
#(
   parameter int WIDTH = MOD_WIDTH
) (
   input  logic [WIDTH:0] r_i,
   input  logic [WIDTH:0] n_i,
   output logic [WIDTH:0] half_o
);

   logic [WIDTH:0] sum_w;

   // r < N < 2^WIDTH, so r+N always fits in WIDTH+1 bits.
   always_comb begin
      sum_w  = r_i[0] ? (r_i + n_i) : r_i;
      half_o = sum_w >> 1;
   end

endmodule

`default_nettype wire

// File: rtl/rsa_two_inv_power_mod.sv
// Computes 2^(-power) mod modulus (odd modulus) by one modular halving per clock,
// behind a valid/ready job stream.
`default_nettype none

module rsa_two_inv_power_mod
   import rsa_two_inv_power_mod_pkg::*;
#(
   parameter int WIDTH     = MOD_WIDTH,
   parameter int CNT_WIDTH = WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               i_ready,
   input  RSATwoInvPowerModIn i_in,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [WIDTH-1:0]   o_out
);

   inv_state_e           state_q, state_d;
   logic [WIDTH:0]       r_q, r_d;
   logic [WIDTH:0]       n_q, n_d;
   logic [CNT_WIDTH-1:0] power_q, power_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]       half_w;
   logic                 accept_w;
   logic                 last_w;
   logic                 zero_pow_w;

   rsa_mod_half #(
      .WIDTH (WIDTH)
   ) u_mod_half (
      .r_i    (r_q),
      .n_i    (n_q),
      .half_o (half_w)
   );

   assign accept_w   = i_valid && i_ready;
   assign zero_pow_w = (CNT_WIDTH'(i_in.power) == '0);
   // Counter starts at 0 and stops at power-1, so it never wraps even at full width.
   assign last_w     = (cnt_q == (power_q - CNT_WIDTH'(1)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept_w) state_d = zero_pow_w ? ST_DONE : ST_RUN;
         ST_RUN:  if (last_w)   state_d = ST_DONE;
         ST_DONE: if (o_ready)  state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      i_ready = (state_q == ST_IDLE);
      o_valid = (state_q == ST_DONE);
      o_out   = (state_q == ST_DONE) ? r_q[WIDTH-1:0] : '0;
   end

   always_comb begin
      r_d     = r_q;
      n_d     = n_q;
      power_d = power_q;
      cnt_d   = cnt_q;
      if (accept_w) begin
         power_d = CNT_WIDTH'(i_in.power);
         n_d     = {1'b0, WIDTH'(i_in.modulus)};
         r_d     = (WIDTH + 1)'(1);
         cnt_d   = '0;
      end else if (state_q == ST_RUN) begin
         r_d   = half_w;
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q     <= '0;
         n_q     <= '0;
         power_q <= '0;
         cnt_q   <= '0;
      end else begin
         r_q     <= r_d;
         n_q     <= n_d;
         power_q <= power_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

`default_nettype wire
